rx_stream_mux: RTL and testbench

- Generalised N-channel receive-sample reader.
- Sits between the per-channel RX sample FIFOs (read side, system clock domain) and the SMI byte interface.
- Pulls whole samples from one fixed channel or from all channels in round-robin order. Serialises each sample MSB-byte-first onto a byte handshake, tagged with channel ID and start-of-sample.
- Keeps sticky per-channel FIFO-overflow flags for the register block.

---
 rtl/rx_stream_mux_if.sv | 37 +++
 rtl/rx_stream_mux.sv | 119 +++++++++++
 tb/tb_rx_stream_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_stream_mux_if.sv
// Handshake and bus bundle between the RX FIFO read ports, the register block
// and the SMI byte stream. master = the mux side, slave = its environment.
interface rx_stream_mux_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 32,
  parameter int BYTE_W   = 8,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [1:0]               i_mode;
  logic [CH_W-1:0]          i_ch_sel;
  logic [NUM_CH-1:0]        i_fifo_empty;
  logic [NUM_CH-1:0]        i_fifo_full;
  logic [NUM_CH*SAMPLE_W-1:0] i_fifo_data;
  logic [NUM_CH-1:0]        o_fifo_pull;
  logic [BYTE_W-1:0]        o_byte;
  logic                     o_byte_valid;
  logic                     i_byte_ready;
  logic                     o_first;
  logic [CH_W-1:0]          o_ch_id;
  logic                     i_clear_flags;
  logic [NUM_CH-1:0]        o_overflow;
  logic                     o_busy;

  modport master (
    input  i_mode, i_ch_sel, i_fifo_empty, i_fifo_full, i_fifo_data,
           i_byte_ready, i_clear_flags,
    output o_fifo_pull, o_byte, o_byte_valid, o_first, o_ch_id,
           o_overflow, o_busy
  );

  modport slave (
    output i_mode, i_ch_sel, i_fifo_empty, i_fifo_full, i_fifo_data,
           i_byte_ready, i_clear_flags,
    input  o_fifo_pull, o_byte, o_byte_valid, o_first, o_ch_id,
           o_overflow, o_busy
  );
endinterface

// File: rtl/rx_stream_mux.sv
// N-channel RX sample reader: pulls whole samples from one channel or round-robin,
// serialises them MSB byte first with channel tag, and tracks sticky overflow flags.
module rx_stream_mux #(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 32,
  parameter int BYTE_W      = 8,
  parameter int FIFO_RD_LAT = 1,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                i_sys_clk,
  input  logic                i_reset,
  rx_stream_mux_if.master     bus
);
  localparam int NB    = SAMPLE_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_id_q, rr_ptr_q, pick_ch, cand;
  logic                  pick_ok;
  logic [SAMPLE_W-1:0]   shift_q;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            lat_q;
  logic [NUM_CH-1:0]     ovf_q, pull_vec;
  logic                  last_wait, byte_take, last_byte;

  // Channel selection; mode and channel select only matter while IDLE
  always_comb begin
    pick_ok = 1'b0;
    pick_ch = '0;
    cand    = '0;
    if (bus.i_mode == 2'd1) begin
      if (int'(bus.i_ch_sel) < NUM_CH && !bus.i_fifo_empty[bus.i_ch_sel]) begin
        pick_ok = 1'b1;
        pick_ch = bus.i_ch_sel;
      end
    end else if (bus.i_mode == 2'd2) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
        if (!pick_ok && !bus.i_fifo_empty[cand]) begin
          pick_ok = 1'b1;
          pick_ch = cand;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pull_vec  = '0;
    last_wait = (lat_q == 2'(FIFO_RD_LAT - 1));
    byte_take = (state_q == SHIFT) && bus.i_byte_ready;
    last_byte = (idx_q == IDX_W'(NB - 1));
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = WAIT;
          if (!i_reset) pull_vec[pick_ch] = 1'b1;
        end
      end
      WAIT:    if (last_wait) state_d = SHIFT;
      SHIFT:   if (byte_take && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Pull -> WAIT (read latency) -> SHIFT; the shift register drains MSB first
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      ch_id_q  <= '0;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
      shift_q  <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_ok) begin
            ch_id_q <= pick_ch;
            lat_q   <= '0;
            idx_q   <= '0;
            if (bus.i_mode == 2'd2) rr_ptr_q <= pick_ch;
          end
        end
        WAIT: begin
          if (last_wait) shift_q <= bus.i_fifo_data[int'(ch_id_q)*SAMPLE_W +: SAMPLE_W];
          else           lat_q   <= lat_q + 2'd1;
        end
        SHIFT: begin
          if (byte_take) begin
            shift_q <= shift_q << BYTE_W;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A full seen in the same cycle as a clear keeps its flag set
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) ovf_q <= '0;
    else         ovf_q <= (ovf_q & ~{NUM_CH{bus.i_clear_flags}}) | bus.i_fifo_full;
  end

  assign bus.o_fifo_pull  = pull_vec;
  assign bus.o_byte       = shift_q[SAMPLE_W-1 -: BYTE_W];
  assign bus.o_byte_valid = (state_q == SHIFT);
  assign bus.o_first      = (state_q == SHIFT) && (idx_q == '0);
  assign bus.o_ch_id      = ch_id_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_rx_stream_mux.sv
// Directed bench for rx_stream_mux with NUM_CH=2, 32-bit samples, read latency 1.
module tb_rx_stream_mux;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rx_stream_mux_if #(.NUM_CH(2), .SAMPLE_W(32), .BYTE_W(8)) bus();

  rx_stream_mux #(.NUM_CH(2), .SAMPLE_W(32), .BYTE_W(8), .FIFO_RD_LAT(1)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.i_mode        = 2'd0;
    bus.i_ch_sel      = 1'b0;
    bus.i_fifo_empty  = 2'b11;
    bus.i_fifo_full   = 2'b00;
    bus.i_fifo_data   = '0;
    bus.i_byte_ready  = 1'b1;
    bus.i_clear_flags = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_defaults();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_defaults();
    #1;
    checks++;
    if ({bus.o_fifo_pull, bus.o_byte, bus.o_byte_valid, bus.o_first, bus.o_ch_id,
         bus.o_overflow, bus.o_busy} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pull=%b byte=%h vld=%b first=%b ch=%b ovf=%b busy=%b, want all 0",
               bus.o_fifo_pull, bus.o_byte, bus.o_byte_valid, bus.o_first, bus.o_ch_id,
               bus.o_overflow, bus.o_busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.o_busy, bus.o_byte_valid, bus.o_fifo_pull} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b vld=%b pull=%b, want 0 0 00",
               bus.o_busy, bus.o_byte_valid, bus.o_fifo_pull);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    logic       exp_first;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_reset();
    bus.i_fifo_data  = {32'h0, 32'hA1B2C3D4};
    bus.i_fifo_empty = 2'b10;
    bus.i_ch_sel     = 1'b0;
    bus.i_mode       = 2'd1;
    #1;
    checks++;
    if (bus.o_fifo_pull !== 2'b01) begin
      errors++;
      $display("FAIL single_pull: got %b want 01", bus.o_fifo_pull);
    end
    tick();
    bus.i_mode = 2'd0;
    checks++;
    if ({bus.o_fifo_pull, bus.o_busy, bus.o_byte_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL single_wait: got pull=%b busy=%b vld=%b want 00 1 0",
               bus.o_fifo_pull, bus.o_busy, bus.o_byte_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_first = (i == 0);
      checks++;
      if ({bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id, bus.o_fifo_pull} !==
          {1'b1, exp_b[i], exp_first, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL single_byte%0d: got vld=%b byte=%h first=%b ch=%b pull=%b want 1 %h %b 0 00",
                 i, bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id, bus.o_fifo_pull,
                 exp_b[i], exp_first);
      end
    end
    tick();
    checks++;
    if ({bus.o_byte_valid, bus.o_busy, bus.o_fifo_pull} !== 4'b0) begin
      errors++;
      $display("FAIL single_done: got vld=%b busy=%b pull=%b want 0 0 00",
               bus.o_byte_valid, bus.o_busy, bus.o_fifo_pull);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_ch;
    logic [7:0] exp_byte;
    int         n;
    do_reset();
    bus.i_fifo_data  = {32'h22222222, 32'h11111111};
    bus.i_fifo_empty = 2'b00;
    bus.i_mode       = 2'd2;
    #1;
    for (int s = 0; s < 3; s++) begin
      exp_ch   = s[0];
      exp_byte = exp_ch ? 8'h22 : 8'h11;
      n = 0;
      while (bus.o_fifo_pull == 2'b00 && n < 8) begin
        tick();
        n++;
      end
      checks++;
      if (bus.o_fifo_pull !== (2'b01 << exp_ch) || n > 1) begin
        errors++;
        $display("FAIL rr_pull%0d: got %b after %0d idle cycles want %b within 1",
                 s, bus.o_fifo_pull, n, 2'b01 << exp_ch);
      end
      tick();
      if (s == 2) bus.i_mode = 2'd0;
      for (int b = 0; b < 4; b++) begin
        tick();
        checks++;
        if ({bus.o_byte_valid, bus.o_byte, bus.o_ch_id} !== {1'b1, exp_byte, exp_ch}) begin
          errors++;
          $display("FAIL rr_s%0d_b%0d: got vld=%b byte=%h ch=%b want 1 %h %b",
                   s, b, bus.o_byte_valid, bus.o_byte, bus.o_ch_id, exp_byte, exp_ch);
        end
      end
    end
    tick();
  endtask

  task automatic test_rr_skip_empty();
    logic       exp_ch;
    logic [7:0] exp_byte;
    int         n;
    do_reset();
    bus.i_fifo_data  = {32'h22222222, 32'h11111111};
    bus.i_fifo_empty = 2'b10;
    bus.i_mode       = 2'd2;
    #1;
    for (int s = 0; s < 3; s++) begin
      exp_ch   = (s == 2);
      exp_byte = exp_ch ? 8'h22 : 8'h11;
      n = 0;
      while (bus.o_fifo_pull == 2'b00 && n < 8) begin
        tick();
        n++;
      end
      checks++;
      if (bus.o_fifo_pull !== (2'b01 << exp_ch)) begin
        errors++;
        $display("FAIL skip_pull%0d: got %b want %b (empty=%b)",
                 s, bus.o_fifo_pull, 2'b01 << exp_ch, bus.i_fifo_empty);
      end
      tick();
      if (s == 2) bus.i_mode = 2'd0;
      for (int b = 0; b < 4; b++) begin
        tick();
        if (s == 1 && b == 0) bus.i_fifo_empty = 2'b00;
        checks++;
        if ({bus.o_byte, bus.o_ch_id} !== {exp_byte, exp_ch}) begin
          errors++;
          $display("FAIL skip_s%0d_b%0d: got byte=%h ch=%b want %h %b",
                   s, b, bus.o_byte, bus.o_ch_id, exp_byte, exp_ch);
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_fifo_data  = {32'h0, 32'hA1B2C3D4};
    bus.i_fifo_empty = 2'b10;
    bus.i_mode       = 2'd1;
    #1;
    tick();
    bus.i_mode = 2'd0;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.o_byte_valid, bus.o_byte} !== 9'h1C3) begin
      errors++;
      $display("FAIL bp_idx2: got vld=%b byte=%h want 1 c3", bus.o_byte_valid, bus.o_byte);
    end
    bus.i_byte_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id, bus.o_fifo_pull} !==
          {1'b1, 8'hC3, 1'b0, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b byte=%h first=%b ch=%b pull=%b want 1 c3 0 0 00",
                 c, bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id, bus.o_fifo_pull);
      end
    end
    bus.i_byte_ready = 1'b1;
    tick();
    checks++;
    if ({bus.o_byte_valid, bus.o_byte} !== 9'h1D4) begin
      errors++;
      $display("FAIL bp_resume: got vld=%b byte=%h want 1 d4", bus.o_byte_valid, bus.o_byte);
    end
    tick();
    checks++;
    if ({bus.o_byte_valid, bus.o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_done: got vld=%b busy=%b want 0 0", bus.o_byte_valid, bus.o_busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.i_fifo_full = 2'b10;
    tick();
    bus.i_fifo_full = 2'b00;
    checks++;
    if (bus.o_overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_set: got %b want 10", bus.o_overflow);
    end
    tick();
    checks++;
    if (bus.o_overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 10", bus.o_overflow);
    end
    bus.i_fifo_full   = 2'b10;
    bus.i_clear_flags = 1'b1;
    tick();
    bus.i_fifo_full   = 2'b00;
    bus.i_clear_flags = 1'b0;
    checks++;
    if (bus.o_overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 10", bus.o_overflow);
    end
    bus.i_clear_flags = 1'b1;
    tick();
    bus.i_clear_flags = 1'b0;
    checks++;
    if (bus.o_overflow !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 00", bus.o_overflow);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_fifo_data  = {32'h55667788, 32'h0};
    bus.i_fifo_empty = 2'b01;
    bus.i_ch_sel     = 1'b1;
    bus.i_mode       = 2'd1;
    #1;
    tick();
    bus.i_mode = 2'd0;
    tick();
    tick();
    checks++;
    if ({bus.o_byte, bus.o_ch_id, bus.o_first} !== {8'h66, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL arst_pre: got byte=%h ch=%b first=%b want 66 1 0",
               bus.o_byte, bus.o_ch_id, bus.o_first);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_fifo_pull, bus.o_byte, bus.o_byte_valid, bus.o_first, bus.o_ch_id,
         bus.o_overflow, bus.o_busy} !== 16'h0) begin
      errors++;
      $display("FAIL arst_immediate: got pull=%b byte=%h vld=%b first=%b ch=%b ovf=%b busy=%b want all 0",
               bus.o_fifo_pull, bus.o_byte, bus.o_byte_valid, bus.o_first, bus.o_ch_id,
               bus.o_overflow, bus.o_busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.o_busy, bus.o_byte_valid} !== 2'b00) begin
      errors++;
      $display("FAIL arst_no_resume: got busy=%b vld=%b want 0 0", bus.o_busy, bus.o_byte_valid);
    end
    bus.i_mode = 2'd1;
    #1;
    checks++;
    if (bus.o_fifo_pull !== 2'b10) begin
      errors++;
      $display("FAIL arst_new_pull: got %b want 10", bus.o_fifo_pull);
    end
    tick();
    bus.i_mode = 2'd0;
    tick();
    checks++;
    if ({bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id} !== {1'b1, 8'h55, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL arst_fresh_byte0: got vld=%b byte=%h first=%b ch=%b want 1 55 1 1",
               bus.o_byte_valid, bus.o_byte, bus.o_first, bus.o_ch_id);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus.o_byte !== 8'h88) begin
      errors++;
      $display("FAIL arst_fresh_byte3: got %h want 88", bus.o_byte);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip_empty();
    test_backpressure();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
